collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
//  Sequential AABB collision engine: checks one player box against NUM_OBJ object boxes read from an
//  external object table (1-cycle read latency, e.g. block RAM), one object per clock, pipelined.
//  Produces a per-object hit mask, first-hit index and hit count once per scan (typically once per frame).
//  Sits between the object table and game logic; supersedes the single-pair combinational checker.
// PARAMETERS
//  NUM_OBJ   8   number of table entries scanned (>=2)
//  COORD_W  10   width of x/y coordinates
//  SIZE_W   10   width of w/h extents
//  IDX_W     3   object index width, =$clog2(NUM_OBJ)
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  reset_n     in   1             asynchronous active-low reset
//  start       in   1             begin scan; sampled only in IDLE
//  abort       in   1             synchronous cancel of a running scan
//  mode        in   1             0 = touching counts as hit (<=), 1 = strict overlap (<); latched at start
//  p_x,p_y     in   COORD_W       player top-left corner; latched at start
//  p_w,p_h     in   SIZE_W        player width/height; latched at start
//  rd_en       out  1             object table read strobe
//  rd_addr     out  IDX_W         object table read address
//  obj_x,obj_y in   COORD_W       object top-left, valid the cycle after rd_en
//  obj_w,obj_h in   SIZE_W        object extents, valid the cycle after rd_en
//  obj_active  in   1             object enabled; inactive objects never hit
//  busy        out  1             scan in progress
//  done        out  1             one-cycle pulse: results valid
//  hit_mask    out  NUM_OBJ       bit k = object k collided
//  hit_any     out  1             |hit_mask
//  first_idx   out  IDX_W         lowest k with hit; 0 when no hit
//  hit_count   out  IDX_W+1       number of set bits in hit_mask
// BEHAVIOUR
//  Reset: FSM=IDLE; rd_en, rd_addr, busy, done, hit_mask, hit_any, first_idx, hit_count all 0.
//  FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 at edge T0 -> latch player/mode, clear accumulators, go ISSUE; busy=1 from T1.
//   ISSUE: rd_en=1, rd_addr=0..NUM_OBJ-1 in cycles T1..T(NUM_OBJ), one per cycle; after last -> DRAIN.
//   DRAIN: rd_en=0; last data (cycle T(NUM_OBJ+1)) compared and accumulated -> DONE.
//   DONE: done=1 for exactly one cycle T(NUM_OBJ+2), busy=0 that cycle; -> IDLE.
//  Latency start->done = NUM_OBJ+2 cycles; back-to-back start accepted in the IDLE cycle after done.
//  Compare stage: data of address k (valid T(k+2)) is tested combinationally; hit written to an internal
//   hit_mask bit k at end of that cycle; hit_count incremented; first_idx set on first hit only.
//  Hit test (all sums computed at COORD_W+1 bits, no wrap-around):
//   mode0: p_x<=obj_x+obj_w && obj_x<=p_x+p_w && p_y<=obj_y+obj_h && obj_y<=p_y+p_h
//   mode1: same with strict <.  Additionally requires obj_active=1, obj_w!=0, obj_h!=0, p_w!=0, p_h!=0.
//  Outputs hit_mask/hit_any/first_idx/hit_count update only at DONE entry and hold until next accepted start.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  abort=1 in ISSUE/DRAIN: next state IDLE, rd_en=0, busy=0, no done pulse, outputs keep previous scan.
//  abort in DONE: ignored (done still pulses). Player inputs changing mid-scan have no effect.
//  reset_n low mid-scan: immediate return to reset values; no done.
// TESTING
//  1 Reset: reset_n low during scan -> all outputs 0 next cycle; FSM idle, later start works normally.
//  2 NUM_OBJ=8, player (100,100,16,16), obj3=(110,110,8,8) only active -> done at T10, hit_mask=8'h08,
//    first_idx=3, hit_count=1, rd_addr 0..7 on T1..T8.
//  3 Edge touch: obj0=(116,100,8,8): mode0 -> hit_mask bit0=1; mode1 -> 0.
//  4 Wrap: player (1020,1020,10,10), obj at (0,0,10,10) -> no hit (11-bit sums); obj (1015,1015,8,8) -> hit.
//  5 Objects 2,5,6 overlapping, obj5 obj_active=0 -> hit_mask=8'h44, first_idx=2, hit_count=2.
//  6 abort at T4 -> busy=0 at T5, no done, previous results held; start at T3 of a scan ignored.

Source files
------------

// File: rtl/collision_scanner.sv
// Sequential AABB collision engine: scans NUM_OBJ object-table entries against one latched player box,
// one object per clock, and reports hit mask, first hit index and hit count once per scan.
module collision_scanner #(
  parameter int NUM_OBJ = 8,
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 10,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic [SIZE_W-1:0]  p_w,
  input  logic [SIZE_W-1:0]  p_h,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [SIZE_W-1:0]  obj_w,
  input  logic [SIZE_W-1:0]  obj_h,
  input  logic               obj_active,
  output logic               busy,
  output logic               done,
  output logic [NUM_OBJ-1:0] hit_mask,
  output logic               hit_any,
  output logic [IDX_W-1:0]   first_idx,
  output logic [IDX_W:0]     hit_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);

  state_t state_q, state_d;

  logic               mode_q;
  logic [COORD_W-1:0] px_q, py_q;
  logic [SIZE_W-1:0]  pw_q, ph_q;
  logic               vld_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OBJ-1:0] acc_mask, mask_nxt;
  logic               acc_any, any_nxt;
  logic [IDX_W-1:0]   acc_first, first_nxt;
  logic [IDX_W:0]     acc_count, count_nxt;

  logic [COORD_W:0] px0, py0, ox0, oy0, px_end, py_end, ox_end, oy_end;
  logic             ovl_x, ovl_y, hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_ISSUE;
      S_ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (abort)                state_d = S_IDLE;
        else if (rd_addr == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extents are summed one bit wider than coordinates so boxes near the edge never wrap.
  always_comb begin
    px0    = (COORD_W+1)'(px_q);
    py0    = (COORD_W+1)'(py_q);
    ox0    = (COORD_W+1)'(obj_x);
    oy0    = (COORD_W+1)'(obj_y);
    px_end = px0 + (COORD_W+1)'(pw_q);
    py_end = py0 + (COORD_W+1)'(ph_q);
    ox_end = ox0 + (COORD_W+1)'(obj_w);
    oy_end = oy0 + (COORD_W+1)'(obj_h);
    if (mode_q) begin
      ovl_x = (px0 < ox_end) && (ox0 < px_end);
      ovl_y = (py0 < oy_end) && (oy0 < py_end);
    end else begin
      ovl_x = (px0 <= ox_end) && (ox0 <= px_end);
      ovl_y = (py0 <= oy_end) && (oy0 <= py_end);
    end
    hit = vld_q && obj_active && (|obj_w) && (|obj_h) && (|pw_q) && (|ph_q) && ovl_x && ovl_y;

    mask_nxt  = acc_mask | (hit ? (NUM_OBJ'(1) << idx_q) : '0);
    any_nxt   = acc_any | hit;
    first_nxt = (hit && !acc_any) ? idx_q : acc_first;
    count_nxt = acc_count + (IDX_W+1)'(hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      mode_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      pw_q      <= '0;
      ph_q      <= '0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      acc_mask  <= '0;
      acc_any   <= 1'b0;
      acc_first <= '0;
      acc_count <= '0;
      hit_mask  <= '0;
      hit_any   <= 1'b0;
      first_idx <= '0;
      hit_count <= '0;
    end else begin
      vld_q <= rd_en && !abort;
      idx_q <= rd_addr;
      if (vld_q) begin
        acc_mask  <= mask_nxt;
        acc_any   <= any_nxt;
        acc_first <= first_nxt;
        acc_count <= count_nxt;
      end
      case (state_q)
        S_IDLE: if (start && !abort) begin
          mode_q    <= mode;
          px_q      <= p_x;
          py_q      <= p_y;
          pw_q      <= p_w;
          ph_q      <= p_h;
          rd_addr   <= '0;
          acc_mask  <= '0;
          acc_any   <= 1'b0;
          acc_first <= '0;
          acc_count <= '0;
        end
        S_ISSUE: rd_addr <= (abort || rd_addr == LAST) ? '0 : rd_addr + 1'b1;
        // Last object's result is folded in directly so outputs are complete on DONE entry.
        S_DRAIN: if (!abort) begin
          hit_mask  <= mask_nxt;
          hit_any   <= any_nxt;
          first_idx <= first_nxt;
          hit_count <= count_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed-vector bench for collision_scanner with a 1-cycle-latency object table model.
module tb_collision_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [9:0] p_x = '0, p_y = '0, p_w = '0, p_h = '0;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [9:0] obj_x, obj_y, obj_w, obj_h;
  logic       obj_active;
  logic       busy, done, hit_any;
  logic [7:0] hit_mask;
  logic [2:0] first_idx;
  logic [3:0] hit_count;

  logic [9:0] tx [8], ty [8], tw [8], th [8];
  logic       ta [8];

  int nvec = 0;
  int nerr = 0;

  collision_scanner #(.NUM_OBJ(8), .COORD_W(10), .SIZE_W(10), .IDX_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .p_x(p_x), .p_y(p_y), .p_w(p_w), .p_h(p_h),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_active(obj_active),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit_any(hit_any),
    .first_idx(first_idx), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Table model; when not read it presents an active box overlapping typical players,
  // so a compare taken on the wrong cycle shows up as a spurious hit.
  always @(posedge clk) begin
    if (rd_en) begin
      obj_x <= tx[rd_addr]; obj_y <= ty[rd_addr];
      obj_w <= tw[rd_addr]; obj_h <= th[rd_addr];
      obj_active <= ta[rd_addr];
    end else begin
      obj_x <= 10'd100; obj_y <= 10'd100;
      obj_w <= 10'd50;  obj_h <= 10'd50;
      obj_active <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 8; i++) begin
      tx[i] = 10'd100; ty[i] = 10'd100; tw[i] = 10'd20; th[i] = 10'd20; ta[i] = 1'b0;
    end
  endtask

  task automatic set_obj(input int i, input logic [9:0] x, y, w, h, input logic a);
    tx[i] = x; ty[i] = y; tw[i] = w; th[i] = h; ta[i] = a;
  endtask

  task automatic check_res(input string tag, input logic [7:0] m, input logic [2:0] f, input logic [3:0] n);
    chk({tag, "_mask"},  hit_mask, m);
    chk({tag, "_any"},   hit_any, |m);
    chk({tag, "_first"}, first_idx, f);
    chk({tag, "_count"}, hit_count, n);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr"},  rd_addr, 0);
    check_res(tag, 8'h00, 3'd0, 4'd0);
  endtask

  // Call at a negedge in IDLE; returns at the negedge of the done cycle (or after the bound).
  task automatic scan(input string tag, input logic m, input logic [9:0] x, y, w, h, input logic seq);
    int c;
    start = 1'b1; mode = m; p_x = x; p_y = y; p_w = w; p_h = h;
    @(negedge clk);
    start = 1'b0;
    mode = ~m; p_x = 10'd0; p_y = 10'd0; p_w = 10'd1023; p_h = 10'd1023;
    c = 1;
    while (!done && c <= 20) begin
      if (seq) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rd_en"}, rd_en, (c <= 8) ? 1 : 0);
        if (c <= 8) chk({tag, "_rd_addr"}, rd_addr, c - 1);
      end
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, c, 10);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    int seen;
    clear_tbl();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_idle_zero("rst");

    // Single overlapping object
    set_obj(3, 10'd110, 10'd110, 10'd8, 10'd8, 1'b1);
    scan("basic", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b1);
    check_res("basic", 8'h08, 3'd3, 4'd1);
    @(negedge clk);
    chk("basic_done_pulse", done, 0);
    check_res("basic_hold", 8'h08, 3'd3, 4'd1);

    // Edge touch
    clear_tbl();
    set_obj(0, 10'd116, 10'd100, 10'd8, 10'd8, 1'b1);
    scan("touch0", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b0);
    check_res("touch0", 8'h01, 3'd0, 4'd1);
    @(negedge clk);
    scan("touch1", 1'b1, 10'd100, 10'd100, 10'd16, 10'd16, 1'b0);
    check_res("touch1", 8'h00, 3'd0, 4'd0);

    // Near coordinate limit: sums must not wrap
    clear_tbl();
    set_obj(1, 10'd0, 10'd0, 10'd10, 10'd10, 1'b1);
    set_obj(4, 10'd1015, 10'd1015, 10'd8, 10'd8, 1'b1);
    @(negedge clk);
    scan("wrap", 1'b0, 10'd1020, 10'd1020, 10'd10, 10'd10, 1'b0);
    check_res("wrap", 8'h10, 3'd4, 4'd1);

    // Multiple hits, inactive and zero-extent objects
    clear_tbl();
    set_obj(2, 10'd90, 10'd90, 10'd20, 10'd20, 1'b1);
    set_obj(5, 10'd105, 10'd105, 10'd4, 10'd4, 1'b0);
    set_obj(6, 10'd112, 10'd96, 10'd10, 10'd10, 1'b1);
    set_obj(7, 10'd105, 10'd105, 10'd0, 10'd5, 1'b1);
    @(negedge clk);
    scan("multi", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b0);
    check_res("multi", 8'h44, 3'd2, 4'd2);
    @(negedge clk);
    scan("pw0", 1'b0, 10'd100, 10'd100, 10'd0, 10'd16, 1'b0);
    check_res("pw0", 8'h00, 3'd0, 4'd0);
    @(negedge clk);
    scan("multi2", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b0);
    check_res("multi2", 8'h44, 3'd2, 4'd2);

    // Abort mid-scan, start while busy ignored
    @(negedge clk);
    start = 1'b1; mode = 1'b0; p_x = 10'd500; p_y = 10'd500; p_w = 10'd16; p_h = 10'd16;
    @(negedge clk); start = 1'b0;           // T1
    @(negedge clk);                          // T2
    @(negedge clk); start = 1'b1;           // T3
    @(negedge clk); start = 1'b0;           // T4
    chk("abort_addr_t4", rd_addr, 3);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;           // T5
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_done", done, 0);
    check_res("abort_hold", 8'h44, 3'd2, 4'd2);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    chk("abort_quiet", seen, 0);

    // start together with abort in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", busy, 0);
    chk("startabort_rd_en", rd_en, 0);

    // Scan after abort works and reproduces results
    clear_tbl();
    set_obj(3, 10'd110, 10'd110, 10'd8, 10'd8, 1'b1);
    scan("post_abort", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b1);
    check_res("post_abort", 8'h08, 3'd3, 4'd1);

    // Reset mid-scan
    @(negedge clk);
    start = 1'b1; mode = 1'b0; p_x = 10'd100; p_y = 10'd100; p_w = 10'd16; p_h = 10'd16;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    chk("midrst_quiet", seen, 0);
    scan("post_rst", 1'b0, 10'd100, 10'd100, 10'd16, 10'd16, 1'b1);
    check_res("post_rst", 8'h08, 3'd3, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
